// File: rtl/leaf_arb_pkg.sv
// Shared types and helpers for the leaf_node round-robin arbiter.
package leaf_arb_pkg;

  localparam int MAX_REQ = 16;
  localparam int PTR_W   = 4;
  localparam int DATA_W  = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} leaf_arb_state_e;

  // One-hot pick of the first valid requester at or above ptr, wrapping at num.
  // Inputs are zero-extended to MAX_REQ; bits at or above num are ignored.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int                 num = MAX_REQ);
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [PTR_W-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % num);
      if ((k < num) && !found && valid[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/leaf_node.sv
// Shared 8-bit adder leaf: y = a + B (mod 256). A, C and D are configuration
// pass-throughs that do not affect the arithmetic.
module leaf_node #(
  parameter int         A = 0,
  parameter int         B = 0,
  parameter logic [3:0] C = 4'h0,
  parameter logic       D = 1'b0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic unused_cfg_s;

  assign unused_cfg_s = ^{A[0], C, D};
  assign y            = a + B[7:0];

endmodule

// File: rtl/leaf_node_arbiter_rr_grant.sv
// Purely combinational round-robin grant generator.
module rr_grant
  import leaf_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  // Grant the first valid requester from ptr upward, or nothing when disabled.
  always_comb begin
    grant = '0;
    if (enable) begin
      grant = NUM_REQ'(rr_pick(MAX_REQ'(valid), PTR_W'(ptr), NUM_REQ));
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/leaf_node_arbiter.sv
// Round-robin arbiter sharing one leaf_node adder among NUM_REQ requesters,
// with a single-entry tagged result register and an acceptance counter.
module leaf_node_arbiter
  import leaf_arb_pkg::*;
#(
  parameter  int         NUM_REQ = 4,
  parameter  int         A       = 0,
  parameter  int         B       = 0,
  parameter  logic [3:0] C       = 4'h0,
  parameter  logic       D       = 1'b0,
  localparam int         ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [7:0]             rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic [15:0]            txn_count
);

  leaf_arb_state_e    state_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [7:0]         rsp_data_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [15:0]        txn_count_r;

  logic               slot_free_s;
  logic               grant_en_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               accept_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [7:0]         operand_s;
  logic [7:0]         sum_s;
  logic [ID_W-1:0]    next_ptr_s;

  assign slot_free_s = (state_r == EMPTY) || rsp_ready;
  // Reset forces the grant low combinationally, independent of flop state.
  assign grant_en_s  = reset_n && slot_free_s;

  rr_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_grant (
    .valid  (req_valid),
    .ptr    (rr_ptr_r),
    .enable (grant_en_s),
    .grant  (grant_s)
  );

  // Grant is already qualified by req_valid, so any set bit is an acceptance.
  assign accept_s = |grant_s;

  // Encode the one-hot grant and mux the granted operand without using req_data in the grant path.
  always_comb begin
    grant_idx_s = '0;
    operand_s   = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_idx_s = grant_idx_s | (grant_s[i] ? ID_W'(i) : '0);
      operand_s   = operand_s | (grant_s[i] ? req_data[i*8 +: 8] : 8'h00);
    end
  end

  assign next_ptr_s = (grant_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);

  leaf_node #(
    .A (A),
    .B (B),
    .C (C),
    .D (D)
  ) u_leaf_node (
    .a (operand_s),
    .y (sum_s)
  );

  // Output-slot state machine plus result, tag, priority pointer and counter updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= EMPTY;
      rr_ptr_r    <= '0;
      rsp_data_r  <= 8'h00;
      rsp_id_r    <= '0;
      txn_count_r <= 16'h0000;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) state_r <= FULL;
          else          state_r <= EMPTY;
        end
        FULL: begin
          if (rsp_ready && !accept_s) state_r <= EMPTY;
          else                        state_r <= FULL;
        end
        default: state_r <= EMPTY;
      endcase
      if (accept_s) begin
        rsp_data_r  <= sum_s;
        rsp_id_r    <= grant_idx_s;
        rr_ptr_r    <= next_ptr_s;
        txn_count_r <= txn_count_r + 16'd1;
      end else begin
        rsp_data_r  <= rsp_data_r;
        rsp_id_r    <= rsp_id_r;
        rr_ptr_r    <= rr_ptr_r;
        txn_count_r <= txn_count_r;
      end
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = (state_r == FULL);
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;
  assign txn_count = txn_count_r;

endmodule

// File: doc/leaf_node_arbiter.md
# leaf_node_arbiter

Round-robin arbiter and sequencer that shares one `leaf_node` adder instance among `NUM_REQ` independent requesters. Each requester presents an 8-bit operand with a valid/ready handshake. The granted operand passes through the shared `leaf_node` (result = operand + `B`, mod 256). The result is held in a single-entry output register, tagged with the requester index, until the consumer accepts it. The block's parameters pass straight through to the `leaf_node` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `A`, 0: passed through to `leaf_node.A`; no effect on arbitration.
- `B`, 0: passed through to `leaf_node.B`; the addend.
- `C`, 4'h0: passed through to `leaf_node.C`.
- `D`, 1'b0: passed through to `leaf_node.D`.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `req_valid`  input  NUM_REQ  per-requester operand valid.
- `req_data`  input  NUM_REQ×8 (packed, requester i at [8i+7:8i])  operands.
- `req_ready`  output  NUM_REQ  one-hot-or-zero grant; combinational.
- `rsp_valid`  output  1  result register holds a valid result.
- `rsp_data`  output  8  result = granted operand + B, mod 256.
- `rsp_id`  output  ID_W = max(1,$clog2(NUM_REQ))  index of the originating requester.
- `rsp_ready`  input  1  consumer accepts the result this cycle.
- `txn_count`  output  16  number of accepted requests; wraps 0xFFFF→0.

## Operation
- State machine, 2 states (`EMPTY`, `FULL`), mirrored by `rsp_valid`.
  - `EMPTY` → `FULL` on any acceptance.
  - `FULL` → `EMPTY` when `rsp_ready` is high and there is no acceptance in the same cycle.
  - `FULL` → `FULL` when `rsp_ready` is high and there is an acceptance in the same cycle (back-to-back).
  - `FULL` stays `FULL` while `rsp_ready` is low.
- `slot_free` = `!rsp_valid || rsp_ready`.
- Grant: when `slot_free`, pick the first `i` with `req_valid[i]`, scanning upward from `rr_ptr` and wrapping. Assert `req_ready[i]` only for that `i`. All other bits of `req_ready` are 0.
- When not `slot_free`, `req_ready` is all zero.
- `req_ready` must not depend on `req_data`. It may depend on `req_valid`, `rsp_valid`, `rsp_ready` and `rr_ptr`.
- Acceptance (`req_valid[i] && req_ready[i]`) has these effects:
  - Register the `leaf_node` output for `req_data[i]` into `rsp_data`.
  - Set `rsp_id` ← `i`.
  - Set `rr_ptr` ← (i+1) mod `NUM_REQ`.
  - Increment `txn_count` by 1.
- `rr_ptr` changes only on acceptance. An idle cycle or a stalled output leaves priority unchanged.
- While `FULL` and `rsp_ready` is low, `rsp_data` and `rsp_id` are stable.
- Requesters may drop `req_valid` without a grant. No fairness credit is kept for dropped requests.

## Timing
- Reset (`reset_n` low, asynchronous, takes effect immediately):
  - `rsp_valid` = 0, `rsp_data` = 8'h00, `rsp_id` = 0.
  - `rr_ptr` = 0, `txn_count` = 0.
  - `req_ready` = 0. It is combinationally forced to 0 while `reset_n` is low.
- Release: the first grant is possible in the first rising edge after `reset_n` deasserts.
- Reset mid-operation discards any held result. No response is emitted for it.
- Latency: an acceptance at edge t gives `rsp_valid` = 1 with the result after edge t, i.e. 1 cycle.
- Throughput: 1 result per cycle while `rsp_ready` is held high.
- Simultaneous `rsp_ready` and a new acceptance: the old result retires and the new result loads on the same edge. `rsp_valid` stays 1 and there is no bubble.
- Arithmetic: 8-bit wrap. For example, with `B` = 3, operand 8'hFE → 8'h01.
- Worst-case wait for a continuously-valid requester is `NUM_REQ`−1 grants to others.

## Structure
- Package `leaf_arb_pkg`:
  - `typedef enum logic {EMPTY, FULL} leaf_arb_state_e`.
  - Function `rr_pick(valid, ptr)`, returning a one-hot vector, for reuse by the bench model.
- Sub-modules:
  - One `leaf_node` instance with `A`/`B`/`C`/`D` passed through unchanged. Its `a` input is driven by the mux of `req_data` selected by the grant.
  - One sub-module `rr_grant`, purely combinational, parameterized by `NUM_REQ`: inputs `valid`, `ptr`, `enable`; output one-hot `grant`.
- Target size: about 150–250 lines RTL in total.

## Test plan
- Reset check: hold `reset_n` low with all `req_valid` = 1 → `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `txn_count` = 0. Release → grant goes to requester 0 first.
- Single request: `B` = 5, `req_valid[2]` = 1 with data 8'h10, `rsp_ready` = 1 → `req_ready` = 4'b0100. Next cycle: `rsp_valid` = 1, `rsp_data` = 8'h15, `rsp_id` = 2, `txn_count` = 1.
- Round-robin: `NUM_REQ` = 4, all requesters valid continuously, `rsp_ready` = 1 → `rsp_id` sequence 0,1,2,3,0,1…, one result per cycle, no bubbles.
- Backpressure: fill the register, then hold `rsp_ready` = 0 for 5 cycles with requests pending → `req_ready` = 0, `rsp_data`/`rsp_id` stable, `rr_ptr` unchanged. Raise `rsp_ready` → the next grant follows the pointer order.
- Wrap arithmetic and counter:
  - `B` = 3, operand 8'hFE → `rsp_data` = 8'h01.
  - Preload by running 65536 transactions → `txn_count` wraps to 0.
- Reset mid-operation: assert `reset_n` low while `FULL` with pending requests → `rsp_valid` drops to 0 immediately (asynchronous) and `rr_ptr` returns to 0. After release, no stale result appears.
